// File: rtl/mips_hilo_controller_if.sv
// rtl/mips_hilo_controller_if.sv - issue/result bundle between the issue stage and the HI/LO controller
//
// Purpose: groups the issue-stage request and the HI/LO controller responses.
// Ports (master = issue stage, slave = controller):
//   issueValid, issueFunc, rsValue, rtValue, flush  : master -> slave
//   stall, busy, hi, lo, readValue, readValid        : slave -> master
interface mips_hilo_controller_if;
  logic        issueValid;
  logic [5:0]  issueFunc;
  logic [31:0] rsValue;
  logic [31:0] rtValue;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] readValue;
  logic        readValid;

  modport master (
    output issueValid, issueFunc, rsValue, rtValue, flush,
    input  stall, busy, hi, lo, readValue, readValid
  );

  modport slave (
    input  issueValid, issueFunc, rsValue, rtValue, flush,
    output stall, busy, hi, lo, readValue, readValid
  );
endinterface

// File: rtl/mips_hilo_controller.sv
// rtl/mips_hilo_controller.sv - HI/LO multiply/divide sequencer with issue stall
//
// Purpose: executes mult/multu (fixed latency), div/divu (32-step restoring
// divider), mthi/mtlo and mfhi/mflo against the shared HI/LO registers, and
// holds the issue stage while a multiply or divide is in flight.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous active-low reset
//   bus    : slave side of mips_hilo_controller_if (issue request in,
//            stall/busy/hi/lo/readValue/readValid out)
module mips_hilo_controller #(
  parameter int MUL_CYCLES = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  mips_hilo_controller_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  localparam logic [4:0] MUL_START = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_START = 5'd31;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] op_a;     // multiplicand, or raw dividend kept for divide-by-zero
  logic [31:0] op_b;     // multiplier, or divisor magnitude
  logic [31:0] rem_r;
  logic [31:0] quot_r;   // dividend bits shift out of the top, quotient bits in at the bottom
  logic        is_signed;
  logic        neg_q;
  logic        neg_r;

  // Decode
  logic hilo_class;
  logic is_mfhi;
  logic is_mthi;
  logic is_mflo;
  logic is_mtlo;
  logic is_mul;
  logic is_div;
  logic op_signed;
  logic busy;
  logic accept;

  always_comb begin
    hilo_class = 1'b0;
    is_mfhi    = 1'b0;
    is_mthi    = 1'b0;
    is_mflo    = 1'b0;
    is_mtlo    = 1'b0;
    is_mul     = 1'b0;
    is_div     = 1'b0;
    op_signed  = ~bus.issueFunc[0];
    // 0100xx and 0110xx only; 0101xx / 0111xx fall outside the class
    if (bus.issueFunc[5:4] == 2'b01 && !bus.issueFunc[2]) begin
      hilo_class = 1'b1;
      case ({bus.issueFunc[3], bus.issueFunc[1:0]})
        3'b000:  is_mfhi = 1'b1;
        3'b001:  is_mthi = 1'b1;
        3'b010:  is_mflo = 1'b1;
        3'b011:  is_mtlo = 1'b1;
        3'b100,
        3'b101:  is_mul  = 1'b1;
        default: is_div  = 1'b1;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign accept = bus.issueValid & hilo_class & ~busy & ~bus.flush;

  // Multiplier: sign-extend to 64 bits so the low 64 product bits are exact
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
  assign prod_u = {32'b0, op_a} * {32'b0, op_b};

  // One restoring-division step; bit 32 of the trial is the borrow
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        ge;
  logic [31:0] rem_next;
  logic [31:0] quot_next;
  logic [31:0] q_final;
  logic [31:0] r_final;

  always_comb begin
    shifted   = {rem_r, quot_r[31]};
    trial     = shifted - {1'b0, op_b};
    ge        = ~trial[32];
    rem_next  = ge ? trial[31:0] : shifted[31:0];
    quot_next = {quot_r[30:0], ge};
    q_final   = neg_q ? (32'd0 - quot_next) : quot_next;
    r_final   = neg_r ? (32'd0 - rem_next)  : rem_next;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      rem_r     <= 32'd0;
      quot_r    <= 32'd0;
      is_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else if (bus.flush) begin
      // Abort without touching HI/LO, even if an op would finish this edge
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              op_a      <= bus.rsValue;
              op_b      <= bus.rtValue;
              is_signed <= op_signed;
              cnt       <= MUL_START;
              state     <= MUL;
            end
            if (is_div) begin
              op_a   <= bus.rsValue;
              op_b   <= (op_signed && bus.rtValue[31]) ? (32'd0 - bus.rtValue) : bus.rtValue;
              quot_r <= (op_signed && bus.rsValue[31]) ? (32'd0 - bus.rsValue) : bus.rsValue;
              rem_r  <= 32'd0;
              neg_q  <= op_signed & (bus.rsValue[31] ^ bus.rtValue[31]);
              neg_r  <= op_signed & bus.rsValue[31];
              cnt    <= DIV_START;
              state  <= DIV;
            end
            if (is_mthi) hi_r <= bus.rsValue;
            if (is_mtlo) lo_r <= bus.rsValue;
          end
        end
        MUL: begin
          if (cnt == 5'd0) begin
            {hi_r, lo_r} <= is_signed ? prod_s : prod_u;
            state        <= IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DIV: begin
          rem_r  <= rem_next;
          quot_r <= quot_next;
          if (cnt == 5'd0) begin
            if (op_b == 32'd0) begin
              lo_r <= 32'hFFFF_FFFF;
              hi_r <= op_a;
            end else begin
              lo_r <= q_final;
              hi_r <= r_final;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.stall     = bus.issueValid & hilo_class & busy;
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;
  assign bus.readValid = accept & (is_mfhi | is_mflo);
  assign bus.readValue = !bus.readValid ? 32'd0 : (is_mfhi ? hi_r : lo_r);

endmodule

// File: tb/tb_mips_hilo_controller.sv
// tb/tb_mips_hilo_controller.sv - directed self-checking bench for mips_hilo_controller
module tb_mips_hilo_controller;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   n;
  int   bad;

  mips_hilo_controller_if bus ();

  mips_hilo_controller #(.MUL_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.issueValid = 1'b1;
    bus.issueFunc  = f;
    bus.rsValue    = a;
    bus.rtValue    = b;
  endtask

  task automatic idle();
    bus.issueValid = 1'b0;
    bus.issueFunc  = 6'd0;
    bus.rsValue    = 32'd0;
    bus.rtValue    = 32'd0;
    bus.flush      = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 100) begin
      cycles++;
      cyc();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_rvalid", 32'(bus.readValid), 32'd0);
    chk("rst_rvalue", bus.readValue, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);

    // Signed mult -3 * 5
    drive(F_MULT, 32'hFFFF_FFFD, 32'd5);
    #1;
    chk("mult_stall", 32'(bus.stall), 32'd0);
    cyc();
    idle();
    wait_idle(n);
    chk("mult_busy_cycles", 32'(n), 32'd4);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFF1);
    drive(F_MFLO, 32'd0, 32'd0);
    #1;
    chk("mflo_rvalid", 32'(bus.readValid), 32'd1);
    chk("mflo_rvalue", bus.readValue, 32'hFFFF_FFF1);
    cyc();
    idle();

    // Unsigned vs signed with the same operands
    drive(F_MULTU, 32'hFFFF_FFFF, 32'd2);
    cyc();
    idle();
    wait_idle(n);
    chk("multu_hi", bus.hi, 32'h0000_0001);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFE);
    drive(F_MULT, 32'hFFFF_FFFF, 32'd2);
    cyc();
    idle();
    wait_idle(n);
    chk("mults_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mults_lo", bus.lo, 32'hFFFF_FFFE);

    // Signed div -7 / 2
    drive(F_DIV, 32'hFFFF_FFF9, 32'd2);
    cyc();
    idle();
    wait_idle(n);
    chk("div_busy_cycles", 32'(n), 32'd32);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    // Divide by zero
    drive(F_DIVU, 32'd7, 32'd0);
    cyc();
    idle();
    wait_idle(n);
    chk("div0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("div0_hi", bus.hi, 32'h0000_0007);

    // Stall: divu 100 / 7 -> q 14, r 2
    drive(F_DIVU, 32'd100, 32'd7);
    cyc();
    idle();
    cyc();
    cyc();
    drive(F_ADD, 32'd1, 32'd2);
    #1;
    chk("add_nostall", 32'(bus.stall), 32'd0);
    chk("add_busy", 32'(bus.busy), 32'd1);
    idle();
    cyc();
    cyc();
    cyc();
    drive(F_MFHI, 32'd0, 32'd0);
    #1;
    n = 0;
    bad = 0;
    while (bus.stall === 1'b1 && n < 100) begin
      if (bus.readValid !== 1'b0) bad++;
      n++;
      cyc();
    end
    chk("stall_cycles", 32'(n), 32'd27);
    chk("stall_rvalid_low", 32'(bad), 32'd0);
    chk("post_stall_rvalid", 32'(bus.readValid), 32'd1);
    chk("post_stall_rvalue", bus.readValue, 32'd2);
    cyc();
    idle();
    chk("divu_lo", bus.lo, 32'd14);

    // Flush an in-flight div
    drive(F_MTHI, 32'h1234_5678, 32'd0);
    cyc();
    idle();
    chk("mthi_hi", bus.hi, 32'h1234_5678);
    drive(F_DIV, 32'd100, 32'd7);
    cyc();
    idle();
    repeat (9) cyc();
    chk("flush_pre_busy", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_hi", bus.hi, 32'h1234_5678);
    chk("flush_lo", bus.lo, 32'd14);
    drive(F_MFLO, 32'd0, 32'd0);
    bus.flush = 1'b1;
    #1;
    chk("flush_mflo_rvalid", 32'(bus.readValid), 32'd0);
    chk("flush_mflo_rvalue", bus.readValue, 32'd0);
    drive(F_MTLO, 32'hDEAD_BEEF, 32'd0);
    cyc();
    idle();
    chk("flush_mtlo_lo", bus.lo, 32'd14);

    // Reset in the middle of a multiply
    drive(F_MULT, 32'd3, 32'd5);
    cyc();
    idle();
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    drive(F_MULT, 32'd6, 32'd7);
    cyc();
    idle();
    wait_idle(n);
    chk("postrst_busy_cycles", 32'(n), 32'd4);
    chk("postrst_lo", bus.lo, 32'h0000_002A);
    chk("postrst_hi", bus.hi, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_hilo_controller.md
Name: mips_hilo_controller

Overview:
Sequences the shared HI/LO multiply/divide resource for R-type instructions in the Func RHilo (func 010???) and RLong (func 011???) categories. Accepts mult/multu/div/divu, mfhi/mflo and mthi/mtlo from the issue stage. Runs multiplies with a fixed-latency counter and divides with a 32-iteration restoring divider. Stalls the issue stage while the unit is busy.

Parameters:
MUL_CYCLES, 4, busy cycles for mult/multu (legal range 1..15)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
issueValid  input  1  func-sourced R-type instruction present at issue
issueFunc  input  6  func field of that instruction
rsValue  input  32  rs operand (dividend/multiplicand/mthi/mtlo source)
rtValue  input  32  rt operand (divisor/multiplier)
flush  input  1  abort in-flight op and drop current issue
stall  output  1  issue must hold; instruction not accepted
busy  output  1  mult/div in progress
hi  output  32  HI register
lo  output  32  LO register
readValue  output  32  mfhi/mflo result
readValid  output  1  readValue valid this cycle

Behaviour:
- Func decode: 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo, 011000 mult, 011001 multu, 011010 div, 011011 divu. These eight are "hilo-class". All other funcs, including 0101??, 011100-011111 and non-RHilo/RLong funcs, are ignored and never stall.
- States: IDLE, MUL, DIV. busy = (state != IDLE).
- stall = issueValid & hiloClass & busy. It is combinational and does not depend on flush.
- accept = issueValid & hiloClass & !busy & !flush.
- accept mult/multu: capture rs and rt plus the signed flag; cnt <= MUL_CYCLES-1; go to MUL.
- MUL, each edge:
  - cnt==0: {hi,lo} <= 64-bit product (signed or unsigned per flag); go to IDLE.
  - otherwise: cnt--.
- accept div/divu:
  - signed: capture |rs|, |rt| and the sign bits.
  - unsigned: capture raw values.
  - Set iteration counter to 31; go to DIV.
- DIV: one restoring step per edge (shift remainder, trial-subtract, set quotient bit). On the step at counter 0:
  - Signed sign fix-up: quotient negated if the signs differ; remainder takes the dividend's sign.
  - lo <= quotient, hi <= remainder; go to IDLE.
- Divisor zero (either signedness): final lo=FFFFFFFF, hi=rsValue as captured at issue.
- Latency: busy is high for exactly MUL_CYCLES (mult) or 32 (div) cycles after the accept edge. hi/lo update on the edge that ends the last busy cycle. A hilo-class op in the following cycle is accepted and sees the new values.
- accept mthi/mtlo (only in IDLE): hi or lo <= rsValue at that edge.
- mfhi/mflo:
  - readValid = accept & (func is mfhi or mflo).
  - readValue = hi or lo, combinational from current registers; 0 when readValid=0.
- flush:
  - Next edge: state <= IDLE; hi/lo are not modified, including a MUL/DIV completing on that same edge.
  - Same-cycle issue is dropped, and readValid=0.
- reset (reset==0 at an edge): state IDLE, hi=lo=0, counters 0. It overrides flush and issue and aborts any in-flight op.
- Outputs after reset: busy=0, stall=0, readValid=0, readValue=0.

Test Plan:
- Signed mult: mult rs=FFFFFFFD (-3), rt=5 -> stall 0 at issue, busy 1 for 4 cycles, then hi=FFFFFFFF, lo=FFFFFFF1. mflo on the next cycle -> readValid=1, readValue=FFFFFFF1.
- Unsigned mult: multu rs=FFFFFFFF, rt=2 -> hi=00000001, lo=FFFFFFFE. The same operands with signed mult -> hi=FFFFFFFF, lo=FFFFFFFE.
- Signed div: div rs=FFFFFFF9 (-7), rt=2 -> busy exactly 32 cycles, then lo=FFFFFFFD, hi=FFFFFFFF. divu rs=7, rt=0 -> lo=FFFFFFFF, hi=00000007.
- Stall: issue mfhi 5 cycles after a div -> stall=1 and readValid=0 for the remaining 27 busy cycles. First non-stalled cycle -> readValue = new hi. An unrelated func (100000 add) during busy -> stall=0.
- Flush: mthi rs=12345678, then div, then flush at busy cycle 10 -> busy 0 next cycle, hi stays 12345678. flush with a same-cycle mtlo -> lo unchanged.
- Reset mid-op: reset low for one edge during MUL -> busy 0, hi=lo=0 next cycle. A mult issued immediately after completes normally.
